// File: rtl/grf_write_arbiter_if.sv
// Bundle of the register-file write arbiter's request, reservation, query and write-port signals.
interface grf_write_arbiter_if;
    logic        w0_valid;
    logic [4:0]  w0_addr;
    logic [31:0] w0_data;
    logic [31:0] w0_pc;
    logic        w0_ready;

    logic        w1_valid;
    logic [4:0]  w1_addr;
    logic [31:0] w1_data;
    logic [31:0] w1_pc;
    logic        w1_ready;

    logic        rsv_valid;
    logic [4:0]  rsv_addr;
    logic        rsv_ready;

    logic [4:0]  q_a1;
    logic [4:0]  q_a2;
    logic        q_stall;

    logic        grf_we;
    logic [4:0]  grf_a3;
    logic [31:0] grf_wd;
    logic [31:0] grf_pc4;

    modport master (
        output w0_valid, w0_addr, w0_data, w0_pc,
        input  w0_ready,
        output w1_valid, w1_addr, w1_data, w1_pc,
        input  w1_ready,
        output rsv_valid, rsv_addr,
        input  rsv_ready,
        output q_a1, q_a2,
        input  q_stall,
        input  grf_we, grf_a3, grf_wd, grf_pc4
    );

    modport slave (
        input  w0_valid, w0_addr, w0_data, w0_pc,
        output w0_ready,
        input  w1_valid, w1_addr, w1_data, w1_pc,
        output w1_ready,
        input  rsv_valid, rsv_addr,
        output rsv_ready,
        input  q_a1, q_a2,
        output q_stall,
        output grf_we, grf_a3, grf_wd, grf_pc4
    );
endinterface

// File: rtl/grf_write_arbiter.sv
// Two-source register-file write arbiter with starvation guard and long-latency busy scoreboard.
// Optional write trace enabled by defining GRF_ARB_TRACE_EN.
module grf_write_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                reset,
    grf_write_arbiter_if.slave  arb
);
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0]  starve_q, starve_d;
    logic [31:0] busy_q, busy_d;
    logic        we_q, we_d;
    logic [4:0]  a3_q, a3_d;
    logic [31:0] wd_q, wd_d;
    logic [31:0] pc4_q, pc4_d;

    logic        starved_s;
    logic        w0_ready_s, w1_ready_s, rsv_ready_s;
    logic        grant0_s, grant1_s;
    logic        rsv_take_s;
    logic        q_stall_s;

    // Grant selection, scoreboard update and next write-port values
    always_comb begin
        starved_s   = 1'b0;
        w0_ready_s  = 1'b0;
        w1_ready_s  = 1'b0;
        rsv_ready_s = 1'b0;
        grant0_s    = 1'b0;
        grant1_s    = 1'b0;
        rsv_take_s  = 1'b0;
        q_stall_s   = 1'b0;
        starve_d    = starve_q;
        busy_d      = busy_q;
        we_d        = 1'b0;
        a3_d        = a3_q;
        wd_d        = wd_q;
        pc4_d       = pc4_q;

        if (reset) begin
            starve_d = 4'd0;
            busy_d   = 32'd0;
            a3_d     = 5'd0;
            wd_d     = 32'd0;
            pc4_d    = 32'd0;
        end else begin
            // Requester 1 pre-empts requester 0 once it has lost LIMIT cycles in a row
            starved_s   = arb.w1_valid && (starve_q == LIMIT);
            w0_ready_s  = !starved_s;
            w1_ready_s  = !arb.w0_valid || (starve_q == LIMIT);
            rsv_ready_s = !busy_q[arb.rsv_addr];
            grant0_s    = arb.w0_valid && w0_ready_s;
            grant1_s    = arb.w1_valid && w1_ready_s;
            rsv_take_s  = arb.rsv_valid && rsv_ready_s && (arb.rsv_addr != 5'd0);

            if (!arb.w1_valid || grant1_s) begin
                starve_d = 4'd0;
            end else begin
                starve_d = starve_q + 4'd1;
            end

            // Clear first so a same-cycle reservation of the same register wins
            if (grant1_s) begin
                busy_d[arb.w1_addr] = 1'b0;
            end else begin
                busy_d = busy_q;
            end
            if (rsv_take_s) begin
                busy_d[arb.rsv_addr] = 1'b1;
            end else begin
                busy_d[0] = busy_d[0];
            end

            if (grant0_s) begin
                we_d  = (arb.w0_addr != 5'd0);
                a3_d  = arb.w0_addr;
                wd_d  = arb.w0_data;
                pc4_d = arb.w0_pc + 32'd4;
            end else if (grant1_s) begin
                we_d  = (arb.w1_addr != 5'd0);
                a3_d  = arb.w1_addr;
                wd_d  = arb.w1_data;
                pc4_d = arb.w1_pc + 32'd4;
            end else begin
                we_d = 1'b0;
            end
        end

        q_stall_s = (busy_q[arb.q_a1] && (arb.q_a1 != 5'd0)) ||
                    (busy_q[arb.q_a2] && (arb.q_a2 != 5'd0));
    end

    // State and registered write-port update
    always_ff @(posedge clk) begin
        starve_q <= starve_d;
        busy_q   <= busy_d;
        we_q     <= reset ? 1'b0 : we_d;
        a3_q     <= a3_d;
        wd_q     <= wd_d;
        pc4_q    <= pc4_d;
    end

    assign arb.w0_ready  = w0_ready_s;
    assign arb.w1_ready  = w1_ready_s;
    assign arb.rsv_ready = rsv_ready_s;
    assign arb.q_stall   = q_stall_s;
    assign arb.grf_we    = we_q;
    assign arb.grf_a3    = a3_q;
    assign arb.grf_wd    = wd_q;
    assign arb.grf_pc4   = pc4_q;

`ifdef GRF_ARB_TRACE_EN
    logic src_q;

    // Remember which requester produced the pending write for the trace
    always_ff @(posedge clk) begin
        if (reset) begin
            src_q <= 1'b0;
        end else if (grant0_s || grant1_s) begin
            src_q <= grant1_s;
        end else begin
            src_q <= src_q;
        end
    end

    // Print each register-file write as it is presented
    always_ff @(posedge clk) begin
        if (we_q) begin
            $display("%0t grf_arb src=%0d pc=%08h a3=%0d wd=%08h",
                     $time, src_q, pc4_q - 32'd4, a3_q, wd_q);
        end
    end
`endif
endmodule

// File: tb/tb_grf_write_arbiter.sv
// Directed self-checking bench for grf_write_arbiter (STARVE_LIMIT = 4).
module tb_grf_write_arbiter;
    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    grf_write_arbiter_if arb_if ();

    grf_write_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .arb   (arb_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        arb_if.w0_valid  = 1'b0; arb_if.w0_addr = 5'd0; arb_if.w0_data = 32'd0; arb_if.w0_pc = 32'd0;
        arb_if.w1_valid  = 1'b0; arb_if.w1_addr = 5'd0; arb_if.w1_data = 32'd0; arb_if.w1_pc = 32'd0;
        arb_if.rsv_valid = 1'b0; arb_if.rsv_addr = 5'd0;
        arb_if.q_a1      = 5'd0; arb_if.q_a2 = 5'd0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        arb_if.w0_valid = 1'b1; arb_if.w1_valid = 1'b1; arb_if.rsv_valid = 1'b1; arb_if.rsv_addr = 5'd4;
        step();
        step();
        vectors++;
        if ({arb_if.w0_ready, arb_if.w1_ready, arb_if.rsv_ready} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_readies got=%b exp=000", {arb_if.w0_ready, arb_if.w1_ready, arb_if.rsv_ready});
        end
        vectors++;
        if ({arb_if.grf_we, arb_if.grf_a3, arb_if.grf_wd, arb_if.grf_pc4} !== 70'd0) begin
            miscompares++;
            $display("FAIL reset_port got we=%b a3=%0d wd=%h pc4=%h exp all 0",
                     arb_if.grf_we, arb_if.grf_a3, arb_if.grf_wd, arb_if.grf_pc4);
        end
        idle();
        reset = 1'b0;
        step();
    endtask

    task automatic test_w0_basic();
        arb_if.w0_valid = 1'b1; arb_if.w0_addr = 5'd5; arb_if.w0_data = 32'h1234; arb_if.w0_pc = 32'h3000;
        #1;
        vectors++;
        if (arb_if.w0_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL w0_ready got=%b exp=1", arb_if.w0_ready);
        end
        step();
        idle();
        vectors++;
        if ({arb_if.grf_we, arb_if.grf_a3, arb_if.grf_wd, arb_if.grf_pc4} !== {1'b1, 5'd5, 32'h1234, 32'h3004}) begin
            miscompares++;
            $display("FAIL w0_write got we=%b a3=%0d wd=%h pc4=%h exp 1/5/1234/3004",
                     arb_if.grf_we, arb_if.grf_a3, arb_if.grf_wd, arb_if.grf_pc4);
        end
        step();
        vectors++;
        if ({arb_if.grf_we, arb_if.grf_a3, arb_if.grf_wd} !== {1'b0, 5'd5, 32'h1234}) begin
            miscompares++;
            $display("FAIL w0_hold got we=%b a3=%0d wd=%h exp 0/5/1234", arb_if.grf_we, arb_if.grf_a3, arb_if.grf_wd);
        end
    endtask

    task automatic test_starve();
        logic [1:0] exp_rdy;
        logic [4:0] exp_a3;
        arb_if.w0_valid = 1'b1; arb_if.w0_addr = 5'd1; arb_if.w0_data = 32'hA0; arb_if.w0_pc = 32'h100;
        arb_if.w1_valid = 1'b1; arb_if.w1_addr = 5'd2; arb_if.w1_data = 32'hB0; arb_if.w1_pc = 32'h200;
        for (int c = 0; c < 10; c++) begin
            exp_rdy = ((c % 5) == 4) ? 2'b01 : 2'b10;
            exp_a3  = ((c % 5) == 4) ? 5'd2 : 5'd1;
            #1;
            vectors++;
            if ({arb_if.w0_ready, arb_if.w1_ready} !== exp_rdy) begin
                miscompares++;
                $display("FAIL starve_rdy cyc=%0d got=%b exp=%b", c, {arb_if.w0_ready, arb_if.w1_ready}, exp_rdy);
            end
            step();
            vectors++;
            if ({arb_if.grf_we, arb_if.grf_a3} !== {1'b1, exp_a3}) begin
                miscompares++;
                $display("FAIL starve_wr cyc=%0d got we=%b a3=%0d exp 1/%0d", c, arb_if.grf_we, arb_if.grf_a3, exp_a3);
            end
        end
        idle();
        step();
    endtask

    task automatic test_scoreboard();
        arb_if.rsv_valid = 1'b1; arb_if.rsv_addr = 5'd8;
        #1;
        vectors++;
        if (arb_if.rsv_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL sb_rsv_ready got=%b exp=1", arb_if.rsv_ready);
        end
        step();
        arb_if.rsv_valid = 1'b0;
        arb_if.q_a1 = 5'd8;
        arb_if.w1_valid = 1'b1; arb_if.w1_addr = 5'd8; arb_if.w1_data = 32'hBEEF; arb_if.w1_pc = 32'h400;
        #1;
        vectors++;
        if ({arb_if.q_stall, arb_if.w1_ready} !== 2'b11) begin
            miscompares++;
            $display("FAIL sb_stall got stall/w1_ready=%b exp=11", {arb_if.q_stall, arb_if.w1_ready});
        end
        step();
        arb_if.w1_valid = 1'b0;
        #1;
        vectors++;
        if ({arb_if.q_stall, arb_if.grf_we, arb_if.grf_a3, arb_if.grf_wd, arb_if.grf_pc4} !==
            {1'b0, 1'b1, 5'd8, 32'hBEEF, 32'h404}) begin
            miscompares++;
            $display("FAIL sb_clear got stall=%b we=%b a3=%0d wd=%h pc4=%h exp 0/1/8/beef/404",
                     arb_if.q_stall, arb_if.grf_we, arb_if.grf_a3, arb_if.grf_wd, arb_if.grf_pc4);
        end
        idle();
        step();
    endtask

    task automatic test_set_wins();
        arb_if.rsv_valid = 1'b1; arb_if.rsv_addr = 5'd8;
        arb_if.w1_valid  = 1'b1; arb_if.w1_addr = 5'd8; arb_if.w1_data = 32'h55;
        step();
        idle();
        arb_if.q_a2 = 5'd8;
        arb_if.rsv_valid = 1'b1; arb_if.rsv_addr = 5'd8;
        #1;
        vectors++;
        if ({arb_if.q_stall, arb_if.rsv_ready, arb_if.grf_we} !== 3'b101) begin
            miscompares++;
            $display("FAIL set_wins got stall/rsv_ready/we=%b exp=101",
                     {arb_if.q_stall, arb_if.rsv_ready, arb_if.grf_we});
        end
        idle();
        step();
    endtask

    task automatic test_zero_addr();
        arb_if.w0_valid = 1'b1; arb_if.w0_addr = 5'd0; arb_if.w0_data = 32'hFFFF; arb_if.w0_pc = 32'h500;
        arb_if.rsv_valid = 1'b1; arb_if.rsv_addr = 5'd0;
        #1;
        vectors++;
        if ({arb_if.w0_ready, arb_if.rsv_ready} !== 2'b11) begin
            miscompares++;
            $display("FAIL zero_ready got w0/rsv=%b exp=11", {arb_if.w0_ready, arb_if.rsv_ready});
        end
        step();
        idle();
        #1;
        vectors++;
        if ({arb_if.grf_we, arb_if.q_stall} !== 2'b00) begin
            miscompares++;
            $display("FAIL zero_write got we/stall=%b exp=00", {arb_if.grf_we, arb_if.q_stall});
        end
        step();
    endtask

    task automatic test_reset_mid();
        arb_if.rsv_valid = 1'b1; arb_if.rsv_addr = 5'd3;
        step();
        arb_if.rsv_addr = 5'd9;
        step();
        idle();
        arb_if.q_a1 = 5'd3; arb_if.q_a2 = 5'd0;
        #1;
        vectors++;
        if (arb_if.q_stall !== 1'b1) begin
            miscompares++;
            $display("FAIL rm_pre_stall got=%b exp=1", arb_if.q_stall);
        end
        reset = 1'b1;
        arb_if.w0_valid = 1'b1; arb_if.w0_addr = 5'd7;
        arb_if.w1_valid = 1'b1; arb_if.w1_addr = 5'd9;
        arb_if.rsv_valid = 1'b1; arb_if.rsv_addr = 5'd12;
        #1;
        vectors++;
        if ({arb_if.w0_ready, arb_if.w1_ready, arb_if.rsv_ready} !== 3'b000) begin
            miscompares++;
            $display("FAIL rm_readies got=%b exp=000", {arb_if.w0_ready, arb_if.w1_ready, arb_if.rsv_ready});
        end
        step();
        reset = 1'b0;
        idle();
        for (int k = 0; k < 3; k++) begin
            arb_if.q_a1 = (k == 0) ? 5'd3 : ((k == 1) ? 5'd9 : 5'd8);
            arb_if.q_a2 = (k == 2) ? 5'd12 : 5'd9;
            #1;
            vectors++;
            if ({arb_if.q_stall, arb_if.grf_we} !== 2'b00) begin
                miscompares++;
                $display("FAIL rm_post k=%0d got stall/we=%b exp=00", k, {arb_if.q_stall, arb_if.grf_we});
            end
        end
        step();
        vectors++;
        if (arb_if.grf_we !== 1'b0) begin
            miscompares++;
            $display("FAIL rm_we_after got=%b exp=0", arb_if.grf_we);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        idle();
        test_reset();
        test_w0_basic();
        test_starve();
        test_scoreboard();
        test_set_wins();
        test_zero_addr();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
